// File: rtl/class_drain_arbiter_if.sv
// Class-drain arbiter bus interface.
//  Groups the class-FIFO side (head words, empty flags, pop strobes), the
//  destination-FIFO side (almost-full flags, push strobes) and the forwarded
//  word with its class tag and busy flag.
//  Handshake: pop_signal/push_signal are single-cycle one-hot strobes. A class
//  FIFO word is "valid" whenever its empty bit is low; the FIFO consumes it on
//  the rising edge that ends a cycle with pop_signal[i]=1. A destination is
//  "ready" whenever its almost-full bit is low; it accepts data_out on the
//  rising edge that ends a cycle with push_signal[j]=1.
//  slave  : the arbiter side (drives strobes and data_out).
//  master : the environment side (drives FIFO status and head words).
interface class_drain_arbiter_if #(
  parameter int LINE_SIZE  = 12,
  parameter int CLASS_BITS = 2
);
  logic [4*LINE_SIZE-1:0] class_data_in;
  logic [3:0]             class_empty;
  logic [3:0]             dest_almost_full;
  logic [3:0]             pop_signal;
  logic [3:0]             push_signal;
  logic [LINE_SIZE-1:0]   data_out;
  logic [CLASS_BITS-1:0]  grant_class;
  logic                   busy;

  modport slave (
    input  class_data_in, class_empty, dest_almost_full,
    output pop_signal, push_signal, data_out, grant_class, busy
  );

  modport master (
    output class_data_in, class_empty, dest_almost_full,
    input  pop_signal, push_signal, data_out, grant_class, busy
  );
endinterface

// File: rtl/class_drain_arbiter.sv
// Class-drain arbiter.
//  Drains four per-class FIFOs into four destination FIFOs chosen by each
//  word's DEST field. Classes whose head word targets an almost-full
//  destination are skipped, so one blocked destination never stalls the
//  others. Each word is popped in one cycle and pushed in the next.
// Ports:
//  clk         : rising-edge clock
//  reset       : asynchronous active-low reset
//  bus         : class/destination FIFO interface (slave modport)
//  dbg_state_o : current FSM state (0 IDLE, 1 POP, 2 PUSH)
module class_drain_arbiter #(
  parameter int LINE_SIZE   = 12,
  parameter int CLASS_BITS  = 2,
  parameter int DEST_BITS   = 2,
  parameter int STRICT_PRIO = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  class_drain_arbiter_if.slave     bus,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t                state_q;
  logic [1:0]            rr_ptr_q;
  logic [DEST_BITS-1:0]  dest_reg_q;
  logic [3:0]            pop_q;
  logic [3:0]            push_q;
  logic [LINE_SIZE-1:0]  data_q;
  logic [CLASS_BITS-1:0] grant_q;
  logic                  busy_q;

  logic [LINE_SIZE-1:0]  head      [4];
  logic [DEST_BITS-1:0]  head_dest [4];
  logic [3:0]            eligible;
  logic                  any_elig;
  logic [1:0]            gnt_idx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i]      = bus.class_data_in[i*LINE_SIZE +: LINE_SIZE];
      head_dest[i] = head[i][LINE_SIZE-CLASS_BITS-1 -: DEST_BITS];
      eligible[i]  = ~bus.class_empty[i] & ~bus.dest_almost_full[head_dest[i]];
    end
  end

  assign any_elig = |eligible;

  // Loops run from lowest to highest priority so the last hit wins.
  // Round-robin order is rr_ptr+1, rr_ptr+2, ... with rr_ptr itself last.
  always_comb begin
    gnt_idx = '0;
    if (STRICT_PRIO != 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (eligible[i]) gnt_idx = 2'(i);
      end
    end else begin
      for (int k = 4; k >= 1; k--) begin
        if (eligible[rr_ptr_q + 2'(k)]) gnt_idx = rr_ptr_q + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd3;
      dest_reg_q <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, PUSH: begin
          push_q <= '0;
          if (any_elig) begin
            // Destination status is only consulted here; the popped word is
            // pushed next cycle regardless of later almost-full changes.
            state_q    <= POP;
            pop_q      <= 4'b0001 << gnt_idx;
            data_q     <= head[gnt_idx];
            grant_q    <= CLASS_BITS'(gnt_idx);
            dest_reg_q <= head_dest[gnt_idx];
            busy_q     <= 1'b1;
            if (STRICT_PRIO == 0) rr_ptr_q <= gnt_idx;
          end else begin
            state_q <= IDLE;
            pop_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        POP: begin
          state_q <= PUSH;
          pop_q   <= '0;
          push_q  <= 4'b0001 << dest_reg_q;
        end
        default: begin
          state_q <= IDLE;
          pop_q   <= '0;
          push_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pop_signal  = pop_q;
  assign bus.push_signal = push_q;
  assign bus.data_out    = data_q;
  assign bus.grant_class = grant_q;
  assign bus.busy        = busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_class_drain_arbiter.sv
module tb_class_drain_arbiter;

  localparam int LS = 12;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  class_drain_arbiter_if #(.LINE_SIZE(LS), .CLASS_BITS(2)) bus ();
  class_drain_arbiter_if #(.LINE_SIZE(LS), .CLASS_BITS(2)) if2 ();

  class_drain_arbiter #(.LINE_SIZE(LS), .CLASS_BITS(2), .DEST_BITS(2), .STRICT_PRIO(0)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state_o(dbg_state)
  );

  class_drain_arbiter #(.LINE_SIZE(LS), .CLASS_BITS(2), .DEST_BITS(2), .STRICT_PRIO(1)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave), .dbg_state_o(dbg_state2)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_count = 0;
  int strict_pops = 0;
  int last_pop_cyc = 0;
  bit have_last_pop = 0;
  bit gap_chk = 0;
  bit last_pop = 0;
  bit last_push = 0;
  logic [3:0] af = 4'b0000;

  logic [LS-1:0] cq [4][$];   // model of the four class FIFOs
  logic [LS-1:0] exp_q[$];    // words popped, awaiting push
  logic [1:0]    exp_grant_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic update_inputs();
    for (int i = 0; i < 4; i++) begin
      if (cq[i].size() > 0) begin
        bus.class_data_in[i*LS +: LS] = cq[i][0];
        bus.class_empty[i] = 1'b0;
      end else begin
        bus.class_data_in[i*LS +: LS] = '0;
        bus.class_empty[i] = 1'b1;
      end
    end
    bus.dest_almost_full = af;
  endtask

  function automatic logic [LS-1:0] mkw(input int c, input int d, input int p);
    logic [LS-1:0] w;
    w = {c[1:0], d[1:0], p[7:0]};
    return w;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor();
    int g;
    logic [LS-1:0] w;
    logic [3:0] dest_oh;
    last_pop  = |bus.pop_signal;
    last_push = |bus.push_signal;
    if (last_pop || last_push)
      check("pop_push_excl", {31'd0, last_pop && last_push}, 32'd0);
    if (last_pop) begin
      pop_count++;
      g = 0;
      for (int i = 0; i < 4; i++) if (bus.pop_signal[i]) g = i;
      check("pop_onehot", {31'd0, $onehot(bus.pop_signal)}, 32'd1);
      check("busy_pop", {31'd0, bus.busy}, 32'd1);
      if (cq[g].size() == 0) begin
        check("pop_from_empty", 32'd1, 32'd0);
      end else begin
        w = cq[g].pop_front();
        check("pop_data", {20'd0, bus.data_out}, {20'd0, w});
        check("pop_grant", {30'd0, bus.grant_class}, g);
        exp_q.push_back(w);
      end
      if (exp_grant_q.size() > 0)
        check("grant_order", g, {30'd0, exp_grant_q.pop_front()});
      if (gap_chk && have_last_pop)
        check("pop_gap", cyc - last_pop_cyc, 32'd2);
      have_last_pop = 1;
      last_pop_cyc = cyc;
    end
    if (last_push) begin
      check("busy_push", {31'd0, bus.busy}, 32'd1);
      if (exp_q.size() == 0) begin
        check("push_unexpected", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        dest_oh = 4'b0001 << w[9:8];
        check("push_data", {20'd0, bus.data_out}, {20'd0, w});
        check("push_dest", {28'd0, bus.push_signal}, {28'd0, dest_oh});
      end
    end
    if (|if2.pop_signal) begin
      strict_pops++;
      check("strict_grant", {28'd0, if2.pop_signal}, 32'd1);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    update_inputs();
  endtask

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_pop && n < 30);
    if (!last_pop) check(tag, 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((cq[0].size() + cq[1].size() + cq[2].size() + cq[3].size() + exp_q.size()) != 0 && n < 80) begin
      step();
      n++;
    end
    check(tag, exp_q.size() + cq[0].size() + cq[1].size() + cq[2].size() + cq[3].size(), 32'd0);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop"},   {28'd0, bus.pop_signal}, 32'd0);
    check({tag, "_push"},  {28'd0, bus.push_signal}, 32'd0);
    check({tag, "_data"},  {20'd0, bus.data_out}, 32'd0);
    check({tag, "_grant"}, {30'd0, bus.grant_class}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    update_inputs();
    if2.class_data_in = {mkw(3, 1, 8'h33), 12'h000, 12'h000, mkw(0, 0, 8'h01)};
    if2.class_empty = 4'b0110;
    if2.dest_almost_full = 4'b0000;
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single word on class 2
    cq[2].push_back(12'hAA5);
    exp_grant_q.push_back(2'd2);
    update_inputs();
    wait_pop("t2_pop_timeout");
    check("t2_pop", {28'd0, bus.pop_signal}, 32'h4);
    check("t2_data", {20'd0, bus.data_out}, 32'hAA5);
    check("t2_grant", {30'd0, bus.grant_class}, 32'd2);
    step();
    check("t2_push", {28'd0, bus.push_signal}, 32'h4);
    check("t2_push_data", {20'd0, bus.data_out}, 32'hAA5);
    step();
    check("t2_idle_state", {30'd0, dbg_state}, 32'd0);
    check("t2_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("t2_idle_push", {28'd0, bus.push_signal}, 32'd0);
    check("t2_hold_data", {20'd0, bus.data_out}, 32'hAA5);

    // Reset asserted mid-PUSH clears outputs without an edge
    cq[1].push_back(mkw(1, 0, 8'h17));
    update_inputs();
    begin : t1_wait
      int n;
      n = 0;
      do begin step(); n++; end while (!last_push && n < 30);
      if (!last_push) check("t1_push_timeout", 32'd0, 32'd1);
    end
    #1 reset = 1'b0;
    #1 check_reset_outputs("t1_midreset");
    for (int i = 0; i < 4; i++) cq[i].delete();
    exp_q.delete();
    exp_grant_q.delete();
    update_inputs();
    #1 reset = 1'b1;

    // Round-robin with all classes loaded, starting from reset
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        cq[i].push_back(mkw(i, (i + k) % 4, 16 * i + k));
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        exp_grant_q.push_back(2'(i));
    have_last_pop = 0;
    gap_chk = 1;
    update_inputs();
    drain("t3_drain");
    gap_chk = 0;
    check("t3_grants_used", exp_grant_q.size(), 32'd0);

    // Blocked destination does not block other classes
    af = 4'b0010;
    cq[0].push_back(mkw(0, 1, 8'h40));
    cq[1].push_back(mkw(1, 3, 8'h51));
    cq[1].push_back(mkw(1, 3, 8'h52));
    exp_grant_q.push_back(2'd1);
    exp_grant_q.push_back(2'd1);
    update_inputs();
    for (int i = 0; i < 12; i++) step();
    check("t4_c0_waiting", cq[0].size(), 32'd1);
    check("t4_c1_served", cq[1].size(), 32'd0);
    af = 4'b0000;
    exp_grant_q.push_back(2'd0);
    update_inputs();
    drain("t4_drain");
    check("t4_grants_used", exp_grant_q.size(), 32'd0);

    // Almost-full rising during POP
    cq[2].push_back(mkw(2, 3, 8'h61));
    cq[2].push_back(mkw(2, 3, 8'h62));
    update_inputs();
    wait_pop("t6_pop_timeout");
    af = 4'b1000;
    update_inputs();
    begin : t6_body
      int pops;
      pops = pop_count;
      step();
      check("t6_push_issued", {28'd0, bus.push_signal}, 32'h8);
      for (int i = 0; i < 8; i++) step();
      check("t6_no_pop", pop_count, pops);
      check("t6_word_waiting", cq[2].size(), 32'd1);
    end
    af = 4'b0000;
    update_inputs();
    drain("t6_drain");

    // Random traffic
    for (int r = 0; r < 40; r++) begin
      int c;
      c = $urandom_range(0, 3);
      if (cq[c].size() < 4) cq[c].push_back(mkw(c, $urandom_range(0, 3), $urandom_range(0, 255)));
      af = 4'($urandom_range(0, 15)) & 4'b0101;
      update_inputs();
      step();
    end
    af = 4'b0000;
    update_inputs();
    drain("rand_drain");

    check("strict_active", {31'd0, strict_pops >= 10}, 32'd1);
    check("final_exp_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
